// File: rtl/adder46_share_arbiter_pkg.sv
// adder46_share_arbiter_pkg
// Shared widths, arbitration-mode encodings and the tie-break helper used by
// the two-port shared mantissa adder.
//   A_W/B_W/SUM_W : operand A, operand B and sum widths
//   NPORTS        : number of requesters sharing the adder
//   ARB_RR/ARB_FIXED : values of the ARB_MODE parameter
package adder46_share_arbiter_pkg;

  localparam int A_W    = 46;
  localparam int B_W    = 26;
  localparam int SUM_W  = 47;
  localparam int NPORTS = 2;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // One-hot grant from the eligible mask. On a tie, port 0 wins when fixed
  // priority is selected or when port 1 was granted last.
  function automatic logic [NPORTS-1:0] arb_pick(input logic [NPORTS-1:0] elig,
                                                 input logic              last,
                                                 input logic              fixed_prio);
    arb_pick = elig;
    if (elig == 2'b11) begin
      arb_pick = (fixed_prio || last) ? 2'b01 : 2'b10;
    end
  endfunction

endpackage

// File: rtl/adder46_share_arbiter_adder.sv
// customAdder46_20
// Purely combinational unsigned adder: 46-bit A plus zero-extended 26-bit B,
// producing a 47-bit sum whose MSB is the carry-out.
//   a   : operand A
//   b   : operand B
//   sum : {carry, A+B}
module customAdder46_20
  import adder46_share_arbiter_pkg::*;
(
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [SUM_W-1:0] sum
);

  assign sum = {1'b0, a} + {{(SUM_W-B_W){1'b0}}, b};

endmodule

// File: rtl/adder46_share_arbiter.sv
// adder46_share_arbiter
// Shares one 46+26-bit adder between two valid/ready requesters. At most one
// request is granted per cycle; its operands are registered (stage 1), added
// and written into that port's response buffer (stage 2). Each port may have
// one transaction outstanding, so its response buffer can never overflow.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : request handshake, bit i = port i
//   req_a0/1, b0/1  : operands per port
//   resp_valid/ready: response handshake, bit i = port i
//   resp_sum0/1     : 47-bit sums, bit 46 = carry-out
//   busy            : registered "any transaction outstanding"
module adder46_share_arbiter
  import adder46_share_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req_valid,
  input  logic [A_W-1:0]    req_a0,
  input  logic [A_W-1:0]    req_a1,
  input  logic [B_W-1:0]    req_b0,
  input  logic [B_W-1:0]    req_b1,
  output logic [NPORTS-1:0] req_ready,
  output logic [NPORTS-1:0] resp_valid,
  output logic [SUM_W-1:0]  resp_sum0,
  output logic [SUM_W-1:0]  resp_sum1,
  input  logic [NPORTS-1:0] resp_ready,
  output logic              busy
);

  localparam logic FIXED_PRIO = (ARB_MODE == ARB_FIXED);

  logic [NPORTS-1:0] outstanding_q, outstanding_d;
  logic              last_grant_q, last_grant_d;
  logic              op_valid_q, op_valid_d;
  logic              op_port_q, op_port_d;
  logic [A_W-1:0]    op_a_q, op_a_d;
  logic [B_W-1:0]    op_b_q, op_b_d;
  logic [NPORTS-1:0] resp_valid_q, resp_valid_d;
  logic [SUM_W-1:0]  resp_sum0_q, resp_sum0_d;
  logic [SUM_W-1:0]  resp_sum1_q, resp_sum1_d;
  logic              busy_q, busy_d;

  logic [NPORTS-1:0] resp_fire;
  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant;
  logic [SUM_W-1:0]  add_sum;

  customAdder46_20 u_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (add_sum)
  );

  always_comb begin
    resp_fire = resp_valid_q & resp_ready;
    // A port whose response is being consumed this cycle may issue again
    // immediately, giving 1-per-2-cycle single-port throughput.
    eligible  = req_valid & (~outstanding_q | resp_fire);
    // Grants are suppressed while in reset so nothing is accepted then.
    grant     = rst ? '0 : arb_pick(eligible, last_grant_q, FIXED_PRIO);

    // Accept sets outstanding after consume clears it, so a same-cycle
    // consume + accept keeps the bit high.
    outstanding_d = (outstanding_q & ~resp_fire) | grant;

    last_grant_d = last_grant_q;
    if (grant[0])      last_grant_d = 1'b0;
    else if (grant[1]) last_grant_d = 1'b1;

    // Stage 1: capture operands of the granted port
    op_valid_d = |grant;
    op_port_d  = op_port_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (grant[0]) begin
      op_port_d = 1'b0;
      op_a_d    = req_a0;
      op_b_d    = req_b0;
    end else if (grant[1]) begin
      op_port_d = 1'b1;
      op_a_d    = req_a1;
      op_b_d    = req_b1;
    end

    // Stage 2: land the adder result in the owning port's buffer
    resp_valid_d = resp_valid_q & ~resp_fire;
    resp_sum0_d  = resp_sum0_q;
    resp_sum1_d  = resp_sum1_q;
    if (op_valid_q) begin
      if (op_port_q) begin
        resp_valid_d[1] = 1'b1;
        resp_sum1_d     = add_sum;
      end else begin
        resp_valid_d[0] = 1'b1;
        resp_sum0_d     = add_sum;
      end
    end

    busy_d = |outstanding_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      last_grant_q  <= 1'b1;
      op_valid_q    <= 1'b0;
      op_port_q     <= 1'b0;
      resp_valid_q  <= '0;
      resp_sum0_q   <= '0;
      resp_sum1_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      last_grant_q  <= last_grant_d;
      op_valid_q    <= op_valid_d;
      op_port_q     <= op_port_d;
      resp_valid_q  <= resp_valid_d;
      resp_sum0_q   <= resp_sum0_d;
      resp_sum1_q   <= resp_sum1_d;
      busy_q        <= busy_d;
    end
  end

  // Operand registers are qualified by op_valid_q and need no reset.
  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_sum0  = resp_sum0_q;
  assign resp_sum1  = resp_sum1_q;
  assign busy       = busy_q;

endmodule
